// File: rtl/cond_flags_unit_pkg.sv
// Shared definitions for the execute-stage condition unit: field widths,
// ARM condition encodings and bit positions within the {N,Z,C,V,Q} vector.
package cond_flags_unit_pkg;

    localparam int NFLAGS = 5;
    localparam int COND_W = 4;

    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;
    localparam logic [COND_W-1:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Q = 0;

endpackage

// File: rtl/cond_flags_unit_cond_check.sv
// Purely combinational ARM condition evaluator: (cond, N, Z, C, V) -> pass.
module cond_check
    import cond_flags_unit_pkg::*;
(
    input  logic [COND_W-1:0] i_cond,
    input  logic              i_n,
    input  logic              i_z,
    input  logic              i_c,
    input  logic              i_v,
    output logic              o_pass
);

    // Decode the condition field against the supplied flags; NV never passes.
    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = i_z;
            COND_NE: o_pass = ~i_z;
            COND_CS: o_pass = i_c;
            COND_CC: o_pass = ~i_c;
            COND_MI: o_pass = i_n;
            COND_PL: o_pass = ~i_n;
            COND_VS: o_pass = i_v;
            COND_VC: o_pass = ~i_v;
            COND_HI: o_pass = i_c & ~i_z;
            COND_LS: o_pass = ~i_c | i_z;
            COND_GE: o_pass = (i_n == i_v);
            COND_LT: o_pass = (i_n != i_v);
            COND_GT: o_pass = ~i_z & (i_n == i_v);
            COND_LE: o_pass = i_z | (i_n != i_v);
            COND_AL: o_pass = 1'b1;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flags_unit.sv
// Execute-stage condition unit. Holds {N,Z,C,V} and sticky Q, evaluates the
// instruction's condition on the held flags, gates its write controls and
// registers them into EX/MEM. Flags written at an edge are seen by the next
// instruction's condition; there is deliberately no bypass from alu_flags.
module cond_flags_unit
    import cond_flags_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic [COND_W-1:0] cond_e,
    input  logic [NFLAGS-1:0] alu_flags,
    input  logic [1:0]        flag_write_e,
    input  logic              q_write_e,
    input  logic              q_clear,
    input  logic              pcs_e,
    input  logic              reg_write_e,
    input  logic              mem_write_e,
    input  logic              mem_to_reg_e,
    output logic              cond_ex_e,
    output logic              pc_src_e,
    output logic              reg_write_m,
    output logic              mem_write_m,
    output logic              mem_to_reg_m,
    output logic [NFLAGS-1:0] flags
);

    logic [NFLAGS-1:0] r_flags;
    logic              r_reg_write_m;
    logic              r_mem_write_m;
    logic              r_mem_to_reg_m;

    logic              w_pass;
    logic              w_cond_ex;
    logic              w_upd;
    logic              w_bubble;
    logic              w_q_next;

    cond_check u_cond_check (
        .i_cond (cond_e),
        .i_n    (r_flags[FLAG_N]),
        .i_z    (r_flags[FLAG_Z]),
        .i_c    (r_flags[FLAG_C]),
        .i_v    (r_flags[FLAG_V]),
        .o_pass (w_pass)
    );

    // A squashed instruction never passes, which also kills its PC write.
    assign w_cond_ex = w_pass & ~flush_e;
    assign w_bubble  = stall_e | flush_e;
    assign w_upd     = ~w_bubble & w_cond_ex;
    // Clear is ungated (MSR path); a same-cycle set wins over it.
    assign w_q_next  = (r_flags[FLAG_Q] & ~q_clear) | (w_upd & q_write_e & alu_flags[FLAG_Q]);

    // Architectural flag register: N,Z and C,V load independently; Q is sticky.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= '0;
        end else begin
            if (w_upd && flag_write_e[1]) begin
                r_flags[FLAG_N] <= alu_flags[FLAG_N];
                r_flags[FLAG_Z] <= alu_flags[FLAG_Z];
            end
            if (w_upd && flag_write_e[0]) begin
                r_flags[FLAG_C] <= alu_flags[FLAG_C];
                r_flags[FLAG_V] <= alu_flags[FLAG_V];
            end
            r_flags[FLAG_Q] <= w_q_next;
        end
    end

    // EX/MEM control register: bubble on stall or flush, else gated controls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_mem_to_reg_m <= 1'b0;
        end else if (w_bubble) begin
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_mem_to_reg_m <= 1'b0;
        end else begin
            r_reg_write_m  <= reg_write_e & w_cond_ex;
            r_mem_write_m  <= mem_write_e & w_cond_ex;
            r_mem_to_reg_m <= mem_to_reg_e;
        end
    end

    assign cond_ex_e    = w_cond_ex;
    assign pc_src_e     = pcs_e & w_cond_ex;
    assign reg_write_m  = r_reg_write_m;
    assign mem_write_m  = r_mem_write_m;
    assign mem_to_reg_m = r_mem_to_reg_m;
    assign flags        = r_flags;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Directed bench for cond_flags_unit with hand-computed expectations.
module tb_cond_flags_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall_e;
    logic       flush_e;
    logic [3:0] cond_e;
    logic [4:0] alu_flags;
    logic [1:0] flag_write_e;
    logic       q_write_e;
    logic       q_clear;
    logic       pcs_e;
    logic       reg_write_e;
    logic       mem_write_e;
    logic       mem_to_reg_e;
    logic       cond_ex_e;
    logic       pc_src_e;
    logic       reg_write_m;
    logic       mem_write_m;
    logic       mem_to_reg_m;
    logic [4:0] flags;

    int total = 0;
    int bad   = 0;

    cond_flags_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall_e      (stall_e),
        .flush_e      (flush_e),
        .cond_e       (cond_e),
        .alu_flags    (alu_flags),
        .flag_write_e (flag_write_e),
        .q_write_e    (q_write_e),
        .q_clear      (q_clear),
        .pcs_e        (pcs_e),
        .reg_write_e  (reg_write_e),
        .mem_write_e  (mem_write_e),
        .mem_to_reg_e (mem_to_reg_e),
        .cond_ex_e    (cond_ex_e),
        .pc_src_e     (pc_src_e),
        .reg_write_m  (reg_write_m),
        .mem_write_m  (mem_write_m),
        .mem_to_reg_m (mem_to_reg_m),
        .flags        (flags)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_e = 0; flush_e = 0; cond_e = 4'b1110; alu_flags = 5'b0;
        flag_write_e = 2'b00; q_write_e = 0; q_clear = 0; pcs_e = 0;
        reg_write_e = 0; mem_write_e = 0; mem_to_reg_e = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        stall_e = 1'($urandom); flush_e = 1'($urandom); cond_e = 4'($urandom);
        alu_flags = 5'($urandom); flag_write_e = 2'($urandom); q_write_e = 1'($urandom);
        q_clear = 1'($urandom); pcs_e = 1'($urandom); reg_write_e = 1;
        mem_write_e = 1; mem_to_reg_e = 1;
        step(); step();
        total++; if (flags !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=%b", flags, 5'b0); end
        total++; if ({reg_write_m, mem_write_m, mem_to_reg_m} !== 3'b000) begin bad++;
            $display("FAIL reset_m got=%b exp=000", {reg_write_m, mem_write_m, mem_to_reg_m}); end
        flush_e = 0; cond_e = 4'b0001; #1;
        total++; if (cond_ex_e !== 1'b1) begin bad++; $display("FAIL reset_ne got=%b exp=1", cond_ex_e); end
        idle_inputs();
        @(negedge clk);
        reset = 1;
        step();
    endtask

    task automatic test_flag_load();
        alu_flags = 5'b01000; flag_write_e = 2'b10; cond_e = 4'b1110; reg_write_e = 1; mem_to_reg_e = 1;
        #1;
        total++; if (cond_ex_e !== 1'b1) begin bad++; $display("FAIL load_al got=%b exp=1", cond_ex_e); end
        step();
        total++; if (flags !== 5'b01000) begin bad++; $display("FAIL load_flags got=%b exp=01000", flags); end
        total++; if (reg_write_m !== 1'b1 || mem_to_reg_m !== 1'b1) begin bad++;
            $display("FAIL load_m got=%b%b exp=11", reg_write_m, mem_to_reg_m); end
        flag_write_e = 2'b00; alu_flags = 5'b0; cond_e = 4'b0000; reg_write_e = 0; mem_to_reg_e = 0;
        #1;
        total++; if (cond_ex_e !== 1'b1) begin bad++; $display("FAIL load_eq got=%b exp=1", cond_ex_e); end
        step();
        total++; if (reg_write_m !== 1'b0) begin bad++; $display("FAIL load_rw_follow got=%b exp=0", reg_write_m); end
    endtask

    task automatic test_cond_table();
        logic [4:0]  set_flags [3] = '{5'b10000, 5'b01100, 5'b00110};
        logic [15:0] exp_pass  [3] = '{16'h6A9A, 16'h66A5, 16'h6966};
        for (int s = 0; s < 3; s++) begin
            idle_inputs();
            alu_flags = set_flags[s]; flag_write_e = 2'b11;
            step();
            flag_write_e = 2'b00; alu_flags = 5'b0;
            total++; if (flags !== set_flags[s]) begin bad++;
                $display("FAIL table_set%0d got=%b exp=%b", s, flags, set_flags[s]); end
            for (int c = 0; c < 16; c++) begin
                logic [15:0] ev;
                ev = exp_pass[s];
                cond_e = 4'(c); #1;
                total++; if (cond_ex_e !== ev[c]) begin bad++;
                    $display("FAIL table_f%0d_c%0d got=%b exp=%b", s, c, cond_ex_e, ev[c]); end
            end
        end
    endtask

    task automatic test_cond_fail();
        idle_inputs();
        alu_flags = 5'b10000; flag_write_e = 2'b11;
        step();
        cond_e = 4'b1010; reg_write_e = 1; mem_write_e = 1; flag_write_e = 2'b11; alu_flags = 5'b01110;
        #1;
        total++; if (cond_ex_e !== 1'b0) begin bad++; $display("FAIL fail_ge got=%b exp=0", cond_ex_e); end
        step();
        total++; if (reg_write_m !== 1'b0 || mem_write_m !== 1'b0) begin bad++;
            $display("FAIL fail_m got=%b%b exp=00", reg_write_m, mem_write_m); end
        total++; if (flags !== 5'b10000) begin bad++; $display("FAIL fail_flags got=%b exp=10000", flags); end
        cond_e = 4'b1011; #1;
        total++; if (cond_ex_e !== 1'b1) begin bad++; $display("FAIL fail_lt got=%b exp=1", cond_ex_e); end
        step();
        total++; if (reg_write_m !== 1'b1 || mem_write_m !== 1'b1) begin bad++;
            $display("FAIL pass_m got=%b%b exp=11", reg_write_m, mem_write_m); end
        total++; if (flags !== 5'b01110) begin bad++; $display("FAIL pass_flags got=%b exp=01110", flags); end
    endtask

    task automatic test_sticky_q();
        idle_inputs();
        alu_flags = 5'b00000; flag_write_e = 2'b11;
        step();
        q_write_e = 1; alu_flags = 5'b00001; flag_write_e = 2'b00;
        step();
        total++; if (flags !== 5'b00001) begin bad++; $display("FAIL q_set got=%b exp=00001", flags); end
        q_write_e = 0; alu_flags = 5'b00000; flag_write_e = 2'b11;
        step();
        total++; if (flags[0] !== 1'b1) begin bad++; $display("FAIL q_hold got=%b exp=1", flags[0]); end
        flag_write_e = 2'b00; q_clear = 1; q_write_e = 1; alu_flags = 5'b00001;
        step();
        total++; if (flags[0] !== 1'b1) begin bad++; $display("FAIL q_set_wins got=%b exp=1", flags[0]); end
        q_write_e = 0; alu_flags = 5'b0;
        step();
        total++; if (flags[0] !== 1'b0) begin bad++; $display("FAIL q_clear got=%b exp=0", flags[0]); end
        q_clear = 0; q_write_e = 1; alu_flags = 5'b00001; cond_e = 4'b1111;
        step();
        total++; if (flags[0] !== 1'b0) begin bad++; $display("FAIL q_nv_gated got=%b exp=0", flags[0]); end
    endtask

    task automatic test_stall_flush();
        idle_inputs();
        stall_e = 1; flag_write_e = 2'b11; alu_flags = 5'b11110; pcs_e = 1;
        reg_write_e = 1; mem_write_e = 1; mem_to_reg_e = 1;
        #1;
        total++; if (pc_src_e !== 1'b1 || cond_ex_e !== 1'b1) begin bad++;
            $display("FAIL stall_pcsrc got=%b%b exp=11", pc_src_e, cond_ex_e); end
        step();
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL stall_flags got=%b exp=00000", flags); end
        total++; if ({reg_write_m, mem_write_m, mem_to_reg_m} !== 3'b000) begin bad++;
            $display("FAIL stall_m got=%b exp=000", {reg_write_m, mem_write_m, mem_to_reg_m}); end
        stall_e = 0; flush_e = 1; #1;
        total++; if (pc_src_e !== 1'b0 || cond_ex_e !== 1'b0) begin bad++;
            $display("FAIL flush_pcsrc got=%b%b exp=00", pc_src_e, cond_ex_e); end
        step();
        total++; if (flags !== 5'b00000 || {reg_write_m, mem_write_m, mem_to_reg_m} !== 3'b000) begin bad++;
            $display("FAIL flush_state got=%b/%b exp=00000/000", flags, {reg_write_m, mem_write_m, mem_to_reg_m}); end
        stall_e = 1; #1;
        total++; if (pc_src_e !== 1'b0) begin bad++; $display("FAIL both_pcsrc got=%b exp=0", pc_src_e); end
        step();
        total++; if (flags !== 5'b00000 || mem_to_reg_m !== 1'b0) begin bad++;
            $display("FAIL both_state got=%b/%b exp=00000/0", flags, mem_to_reg_m); end
        stall_e = 0; flush_e = 0; mem_write_e = 0;
        step();
        total++; if (flags !== 5'b11110 || {reg_write_m, mem_write_m, mem_to_reg_m} !== 3'b101) begin bad++;
            $display("FAIL resume got=%b/%b exp=11110/101", flags, {reg_write_m, mem_write_m, mem_to_reg_m}); end
        flag_write_e = 2'b00; cond_e = 4'b1111; reg_write_e = 1; mem_to_reg_e = 1;
        step();
        total++; if (reg_write_m !== 1'b0 || mem_to_reg_m !== 1'b1) begin bad++;
            $display("FAIL nv_m2r got=%b%b exp=01", reg_write_m, mem_to_reg_m); end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        cond_e = 4'b0000; flag_write_e = 2'b10; alu_flags = 5'b00000; #1;
        total++; if (cond_ex_e !== 1'b1) begin bad++; $display("FAIL b2b_first got=%b exp=1", cond_ex_e); end
        step();
        total++; if (flags !== 5'b00110) begin bad++; $display("FAIL b2b_flags got=%b exp=00110", flags); end
        alu_flags = 5'b01000; #1;
        total++; if (cond_ex_e !== 1'b0) begin bad++; $display("FAIL b2b_nobypass got=%b exp=0", cond_ex_e); end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        flag_write_e = 2'b11; alu_flags = 5'b11110; reg_write_e = 1;
        step();
        total++; if (flags !== 5'b11110) begin bad++; $display("FAIL ar_pre got=%b exp=11110", flags); end
        #2 reset = 0;
        #1;
        total++; if (flags !== 5'b00000 || reg_write_m !== 1'b0) begin bad++;
            $display("FAIL ar_async got=%b/%b exp=00000/0", flags, reg_write_m); end
        @(negedge clk);
        reset = 1;
        alu_flags = 5'b01000; flag_write_e = 2'b11;
        step();
        total++; if (flags !== 5'b01000 || reg_write_m !== 1'b1) begin bad++;
            $display("FAIL ar_first_edge got=%b/%b exp=01000/1", flags, reg_write_m); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_flag_load();
        test_cond_table();
        test_cond_fail();
        test_sticky_q();
        test_stall_flush();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
